// File: rtl/vx_warp_issue_sched_if.sv
// Fetch-offer channel between the warp issue scheduler and instruction fetch.
// A warp is issued on any cycle with sched_valid && sched_ready; the offer may change while not ready.
interface vx_warp_issue_sched_if #(
    parameter int NUM_WARPS = 4
);
    localparam int WB = $clog2(NUM_WARPS);

    logic          sched_valid;
    logic [WB-1:0] sched_wid;
    logic          sched_ready;

    modport master (
        output sched_valid,
        output sched_wid,
        input  sched_ready
    );

    modport slave (
        input  sched_valid,
        input  sched_wid,
        output sched_ready
    );
endinterface

// File: rtl/vx_warp_issue_sched.sv
// Per-core warp issue scheduler: round-robin over eligible warps, per-warp in-flight limit,
// and stall tracking from decode wstall/join until execute releases the warp.
module vx_warp_issue_sched #(
    parameter int CORE_ID      = 0,
    parameter int NUM_WARPS    = 4,
    parameter int MAX_INFLIGHT = 1,
    localparam int WB = $clog2(NUM_WARPS),
    localparam int CB = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WARPS-1:0]   active_warps,
    vx_warp_issue_sched_if.master  sched,
    input  logic                   decode_fire_valid,
    input  logic [WB-1:0]          decode_fire_wid,
    input  logic                   wstall_valid,
    input  logic [WB-1:0]          wstall_wid,
    input  logic                   join_valid,
    input  logic [WB-1:0]          join_wid,
    input  logic                   unstall_valid,
    input  logic [WB-1:0]          unstall_wid,
    output logic [NUM_WARPS-1:0]   stalled_mask,
    output logic [31:0]            idle_cycles
);

    logic [NUM_WARPS-1:0] stalled;
    logic [NUM_WARPS-1:0] stalled_nxt;
    logic [CB-1:0]        inflight     [NUM_WARPS];
    logic [CB-1:0]        inflight_nxt [NUM_WARPS];
    logic [WB-1:0]        rr_ptr;
    logic [NUM_WARPS-1:0] eligible;
    logic [WB-1:0]        pick;
    logic [WB-1:0]        idx;
    logic                 found;
    logic                 issue;
    logic                 dec_underflow;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = active_warps[w] && !stalled[w] &&
                          (inflight[w] != CB'(MAX_INFLIGHT));
        end
    end

    // Search begins one past the last granted warp; the index wraps naturally at WB bits.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = rr_ptr + WB'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign sched.sched_valid = found && !reset;
    assign sched.sched_wid   = pick;
    assign issue             = sched.sched_valid && sched.sched_ready;
    assign stalled_mask      = stalled;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            logic inc;
            logic dec;
            logic set;
            logic clr;
            inc = issue && (pick == WB'(w));
            dec = decode_fire_valid && (decode_fire_wid == WB'(w));
            set = (wstall_valid && (wstall_wid == WB'(w))) ||
                  (join_valid && (join_wid == WB'(w)));
            clr = unstall_valid && (unstall_wid == WB'(w));
            stalled_nxt[w]  = set || (stalled[w] && !clr);
            inflight_nxt[w] = inflight[w];
            if (inc && !dec) begin
                inflight_nxt[w] = inflight[w] + CB'(1);
            end else if (dec && !inc && (inflight[w] != '0)) begin
                inflight_nxt[w] = inflight[w] - CB'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stalled     <= '0;
            rr_ptr      <= WB'(NUM_WARPS - 1);
            idle_cycles <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                inflight[w] <= '0;
            end
        end else begin
            stalled <= stalled_nxt;
            for (int w = 0; w < NUM_WARPS; w++) begin
                inflight[w] <= inflight_nxt[w];
            end
            if (issue) begin
                rr_ptr <= pick;
            end
            // Backpressure (valid without ready) is not idle time.
            if ((|active_warps) && !sched.sched_valid) begin
                idle_cycles <= idle_cycles + 32'd1;
            end
        end
    end

    assign dec_underflow = decode_fire_valid && (inflight[decode_fire_wid] == '0) &&
                           !(issue && (pick == decode_fire_wid));

    assert property (@(posedge clk) disable iff (reset) !dec_underflow)
        else $error("core %0d: decode fire on warp %0d with nothing in flight",
                    CORE_ID, decode_fire_wid);

endmodule

// File: tb/tb_vx_warp_issue_sched.sv
// Bench for vx_warp_issue_sched: directed vector table, corner-case sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_vx_warp_issue_sched;

    localparam int N   = 4;
    localparam int MAX = 2;
    localparam int WB  = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  active_warps;
    logic          dv, wv, jv, uv;
    logic [WB-1:0] dw, ww, jw, uw;
    logic [N-1:0]  stalled_mask;
    logic [31:0]   idle_cycles;

    vx_warp_issue_sched_if #(.NUM_WARPS(N)) sif ();

    vx_warp_issue_sched #(
        .CORE_ID(0), .NUM_WARPS(N), .MAX_INFLIGHT(MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .active_warps(active_warps),
        .sched(sif),
        .decode_fire_valid(dv),
        .decode_fire_wid(dw),
        .wstall_valid(wv),
        .wstall_wid(ww),
        .join_valid(jv),
        .join_wid(jw),
        .unstall_valid(uv),
        .unstall_wid(uw),
        .stalled_mask(stalled_mask),
        .idle_cycles(idle_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [WB-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference model
    int          m_inflight [N];
    bit          m_stalled  [N];
    int          m_rr;
    logic [31:0] m_idle;

    function automatic void model_reset();
        for (int w = 0; w < N; w++) begin
            m_inflight[w] = 0;
            m_stalled[w]  = 0;
        end
        m_rr   = N - 1;
        m_idle = 0;
    endfunction

    function automatic void model_offer(output bit v, output int wid);
        v   = 0;
        wid = m_rr;
        for (int k = 1; k <= N; k++) begin
            int w;
            w = (m_rr + k) % N;
            if (!v && active_warps[w] && !m_stalled[w] && m_inflight[w] < MAX) begin
                v   = 1;
                wid = w;
            end
        end
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int w = 0; w < N; w++) m[w] = m_stalled[w];
        return m;
    endfunction

    task automatic check_model();
        bit v;
        int wid;
        model_offer(v, wid);
        check("model_valid", 32'(sif.sched_valid), 32'(v));
        check("model_wid",   32'(sif.sched_wid),   32'(wid));
        check("model_mask",  32'(stalled_mask),    32'(model_mask()));
        check("model_idle",  idle_cycles,          m_idle);
    endtask

    function automatic void model_update();
        bit v;
        int wid;
        model_offer(v, wid);
        if (v && sif.sched_ready) begin
            m_rr = wid;
            m_inflight[wid]++;
        end
        if (dv && m_inflight[dw] > 0) m_inflight[dw]--;
        if (uv) m_stalled[uw] = 0;
        if (wv) m_stalled[ww] = 1;
        if (jv) m_stalled[jw] = 1;
        if ((|active_warps) && !v) m_idle = m_idle + 32'd1;
    endfunction

    // Driver tasks
    task automatic clear_events();
        dv = 0; dw = 0; wv = 0; ww = 0; jv = 0; jw = 0; uv = 0; uw = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_events();
        active_warps    = '0;
        sif.sched_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    typedef struct {
        logic [N-1:0]  active;
        logic          ready;
        logic          dv;
        logic [WB-1:0] dw;
        logic          wv;
        logic [WB-1:0] ww;
        logic          jv;
        logic [WB-1:0] jw;
        logic          uv;
        logic [WB-1:0] uw;
        logic          ev;
        logic [WB-1:0] ew;
        logic [N-1:0]  emask;
    } vec_t;

    vec_t tab [17];

    initial begin
        int issues;
        tab[0]  = '{4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000};
        tab[1]  = '{4'b1111, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000};
        tab[2]  = '{4'b0100, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 4'b0000};
        tab[3]  = '{4'b1111, 0, 1, 2, 1, 2, 0, 0, 0, 0, 1, 3, 4'b0000};
        tab[4]  = '{4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4'b0100};
        tab[5]  = '{4'b0100, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 4'b0100};
        tab[6]  = '{4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4'b0000};
        tab[7]  = '{4'b1000, 0, 0, 0, 0, 0, 1, 3, 1, 3, 1, 3, 4'b0000};
        tab[8]  = '{4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4'b1000};
        tab[9]  = '{4'b1111, 0, 0, 0, 1, 0, 1, 1, 1, 3, 1, 0, 4'b1000};
        tab[10] = '{4'b1111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4'b0011};
        tab[11] = '{4'b1111, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 4'b0011};
        tab[12] = '{4'b1111, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 4'b0010};
        tab[13] = '{4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000};
        tab[14] = '{4'b0010, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000};
        tab[15] = '{4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000};
        tab[16] = '{4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000};

        // Reset state
        reset = 1;
        clear_events();
        active_warps    = 4'b1111;
        sif.sched_ready = 1;
        model_reset();
        #2;
        check("reset_valid", 32'(sif.sched_valid), 0);
        check("reset_mask",  32'(stalled_mask), 0);
        check("reset_idle",  idle_cycles, 0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            active_warps    = tab[i].active;
            sif.sched_ready = tab[i].ready;
            dv = tab[i].dv; dw = tab[i].dw;
            wv = tab[i].wv; ww = tab[i].ww;
            jv = tab[i].jv; jw = tab[i].jw;
            uv = tab[i].uv; uw = tab[i].uw;
            #1;
            check($sformatf("tab%0d_valid", i), 32'(sif.sched_valid), 32'(tab[i].ev));
            check($sformatf("tab%0d_wid", i),   32'(sif.sched_wid),   32'(tab[i].ew));
            check($sformatf("tab%0d_mask", i),  32'(stalled_mask),    32'(tab[i].emask));
            tick();
        end

        // Round-robin order with decode one cycle after issue
        do_reset();
        active_warps    = 4'b1111;
        sif.sched_ready = 1;
        for (int r = 0; r < 3; r++)
            for (int w = 0; w < N; w++) exp_q.push_back(WB'(w));
        begin
            logic [WB-1:0] prev;
            bit have_prev;
            have_prev = 0;
            prev = '0;
            for (int c = 0; c < 12; c++) begin
                clear_events();
                if (have_prev) begin
                    dv = 1;
                    dw = prev;
                end
                #1;
                check("rr_valid", 32'(sif.sched_valid), 1);
                check("rr_order", 32'(sif.sched_wid), 32'(exp_q.pop_front()));
                if (have_prev) check("rr_not_repeat", 32'(sif.sched_wid != prev), 1);
                prev = sif.sched_wid;
                have_prev = 1;
                tick();
            end
        end
        check("rr_idle", idle_cycles, 0);

        // In-flight limit with a single active warp
        do_reset();
        clear_events();
        active_warps    = 4'b0001;
        sif.sched_ready = 1;
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (sif.sched_valid) issues++;
            tick();
        end
        check("limit_issues", 32'(issues), 2);
        check("limit_idle", idle_cycles, 4);
        sif.sched_ready = 0;
        dv = 1; dw = 0;
        tick();
        clear_events();
        sif.sched_ready = 1;
        issues = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (sif.sched_valid) issues++;
            tick();
        end
        check("limit_one_more", 32'(issues), 1);
        check("limit_idle2", idle_cycles, 8);

        // Backpressure, then no active warps
        do_reset();
        active_warps    = 4'b1010;
        sif.sched_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", 32'(sif.sched_valid), 1);
            check("bp_wid_set", 32'(sif.sched_wid == 1 || sif.sched_wid == 3), 1);
            check("bp_idle", idle_cycles, 0);
            tick();
        end
        active_warps = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("none_valid", 32'(sif.sched_valid), 0);
            tick();
        end
        check("none_idle", idle_cycles, 0);

        // Async reset with stalled and in-flight warps
        do_reset();
        active_warps    = 4'b1111;
        sif.sched_ready = 1;
        tick();
        wv = 1; ww = 2; jv = 1; jw = 3;
        tick();
        clear_events();
        tick();
        #2 reset = 1;
        #1;
        check("arst_mask",  32'(stalled_mask), 0);
        check("arst_valid", 32'(sif.sched_valid), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        active_warps    = 4'b0110;
        sif.sched_ready = 0;
        #1;
        check("arst_first_valid", 32'(sif.sched_valid), 1);
        check("arst_first_wid",   32'(sif.sched_wid), 1);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int w;
            clear_events();
            active_warps    = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'b1111;
            sif.sched_ready = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, N - 1);
            if (m_inflight[w] > 0 && $urandom_range(0, 1) == 1) begin
                dv = 1; dw = WB'(w);
            end
            if ($urandom_range(0, 7) == 0) begin wv = 1; ww = WB'($urandom_range(0, N - 1)); end
            if ($urandom_range(0, 9) == 0) begin jv = 1; jw = WB'($urandom_range(0, N - 1)); end
            if ($urandom_range(0, 3) == 0) begin uv = 1; uw = WB'($urandom_range(0, N - 1)); end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_warp_issue_sched.md
# vx_warp_issue_sched

Per-core warp issue scheduler sitting in front of instruction fetch. It selects the next warp to fetch by round-robin over eligible warps, and limits each warp's in-flight fetch/decode instructions. It blocks a warp after decode flags a control-flow or warp-control instruction (wstall or join) until execute resolves it. It closes the loop between the decode stage's wstall/join outputs and the fetch request path.

## Interface
- CORE_ID, 0, core index, used only in debug prints
- NUM_WARPS, 4, warps per core, power of two, ≥2; WB = $clog2(NUM_WARPS)
- MAX_INFLIGHT, 1, max issued-but-not-decoded instructions per warp, 1..7; CB = $clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- active_warps  in  NUM_WARPS  warps currently enabled by warp control
- sched_valid  out  1  a warp is offered for fetch
- sched_wid  out  WB  offered warp id
- sched_ready  in  1  fetch accepts offer; issue = sched_valid && sched_ready
- decode_fire_valid  in  1  decode consumed an instruction
- decode_fire_wid  in  WB  its warp
- wstall_valid  in  1  decoded instruction stalls its warp
- wstall_wid  in  WB  stalled warp
- join_valid  in  1  decoded join stalls its warp
- join_wid  in  WB  joining warp
- unstall_valid  in  1  execute resolved the stalling instruction
- unstall_wid  in  WB  warp to release
- stalled_mask  out  NUM_WARPS  registered stall bits, for perf/debug
- idle_cycles  out  32  perf counter

## Operation
- State per warp: stalled bit; inflight counter, CB bits. Global state: rr_ptr (WB bits, last granted warp); idle_cycles.
- eligible[w] = active_warps[w] && !stalled[w] && inflight[w] != MAX_INFLIGHT.
- Selection:
  - Search starts at rr_ptr+1 (mod NUM_WARPS) and wraps.
  - First eligible warp drives sched_wid; sched_valid = |eligible.
  - If none is eligible, sched_wid = rr_ptr and sched_valid = 0.
- On issue: rr_ptr <= sched_wid and inflight[sched_wid] += 1.
- Offer hold: while sched_valid && !sched_ready, the offer may change next cycle if eligibility changes. There is no hold requirement, because fetch samples only on the ready cycle.
- On decode_fire_valid: inflight[decode_fire_wid] -= 1.
- Same-cycle issue and decode_fire on the same warp: counter unchanged.
- Decrement at 0 is a protocol error: counter stays 0; simulation assertion fires.
- stalled set: wstall_valid or join_valid sets stalled[wid]. Both may fire for different wids in one cycle; both are set.
- stalled clear: unstall_valid clears stalled[unstall_wid].
- Same wid set and clear in one cycle: set wins.
- Unstall of a non-stalled warp: no effect.
- Deasserting active_warps[w]: makes warp w ineligible. Its stalled and inflight state is retained and continues to update from decode/unstall.
- idle_cycles:
  - Increments when (|active_warps) && !sched_valid.
  - Wraps at 2^32.
  - Not incremented when sched_valid && !sched_ready; that is backpressure, not idle.
- stalled_mask = stalled register.

## Timing
- Reset (async assert, sync deassert by upstream): stalled = 0, inflight = 0, rr_ptr = NUM_WARPS-1 (first search starts at warp 0), idle_cycles = 0.
- sched_valid is forced 0 while reset is high; stalled_mask = 0 during reset.
- sched_valid and sched_wid:
  - Combinational from registered state and active_warps only.
  - No combinational path from sched_ready, decode_fire_*, wstall_*, join_*, or unstall_*.
- Stall latency:
  - A wstall/join at cycle N blocks the warp from cycle N+1.
  - An unstall at cycle N makes the warp eligible at N+1, if its other conditions hold.
- Inflight update is visible to eligibility the cycle after issue or decode fire.
- With MAX_INFLIGHT = 1, a warp issued at N is not re-offered before the cycle after its decode fire. So a stalling instruction always blocks the warp before its successor is fetched.
- MAX_INFLIGHT > 1 allows post-branch fetches; discarding them is the pipeline's responsibility.
- Reset mid-operation clears all stall and inflight state; upstream/downstream are reset concurrently.

## Test plan
- Round-robin:
  - Stimulus: reset, active_warps = 4'b1111, sched_ready = 1, decode_fire for each issued warp one cycle after issue, MAX_INFLIGHT = 1.
  - Required: issue order 0,1,2,3,0,…, never the same warp in consecutive cycles; idle_cycles increments only on cycles with no eligible warp.
- Stall and release:
  - Stimulus: issue warp 2, then decode_fire + wstall_valid on wid 2 at cycle N.
  - Required: warp 2 is not offered from N+1; stalled_mask = 4'b0100. After unstall_valid wid 2 at cycle M, warp 2 may be offered at M+1 and stalled_mask = 0.
- Inflight limit:
  - Stimulus: MAX_INFLIGHT = 2, active_warps = 4'b0001, no decode fire.
  - Required: exactly two issues, then sched_valid = 0 and idle_cycles counts each cycle. One decode_fire lets exactly one more issue.
- Simultaneous events:
  - Stimulus: same-cycle issue and decode_fire on warp 1.
  - Required: inflight[1] unchanged.
  - Stimulus: same-cycle join_valid and unstall_valid on wid 3.
  - Required: warp 3 stays stalled.
  - Stimulus: wstall on wid 0 plus join on wid 1 in one cycle.
  - Required: stalled_mask = 4'b0011.
- Backpressure and inactive warps:
  - Stimulus: sched_ready = 0 for 5 cycles with active_warps = 4'b1010.
  - Required: sched_valid = 1 and sched_wid ∈ {1,3}, no state change, idle_cycles unchanged.
  - Stimulus: active_warps = 0.
  - Required: sched_valid = 0 and idle_cycles frozen.
- Async reset:
  - Stimulus: assert reset mid-run with warps stalled and inflight nonzero.
  - Required: stalled_mask = 0 and sched_valid = 0 immediately. After release, the first offered warp is the lowest active one.
